// File: rtl/rf_wb_pkg.sv
// Shared definitions for the register-file write-back arbiter.
// Purpose : the default requester count and the address/data widths, the
//           requester id type, the requester index constants, and a
//           saturating increment used by the wait counters.
package rf_wb_pkg;

    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;

    typedef logic [1:0] req_id_t;

    localparam req_id_t REQ_ALU  = 2'd0;
    localparam req_id_t REQ_LOAD = 2'd1;
    localparam req_id_t REQ_MDU  = 2'd2;

    // Increment a 3-bit counter, but never go past the ceiling.
    function automatic logic [2:0] sat_inc3(input logic [2:0] v, input logic [2:0] ceil);
        logic [2:0] r;
        if (v >= ceil) begin
            r = ceil;
        end else begin
            r = v + 3'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rf_wb_prio_pick.sv
// Priority picker with a movable starting point.
// Purpose : returns a one-hot grant for the first set bit of i_valid found
//           while searching upward from i_base and wrapping N-1 -> 0.
// Ports   : i_valid - request vector
//           i_base  - index where the search starts
//           o_grant - one-hot grant, all zero when nothing is valid
module rf_wb_prio_pick #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_valid,
    input  logic [IW-1:0] i_base,
    output logic [N-1:0]  o_grant
);

    // Walk the requesters in circular order from the base; the first valid one wins.
    always_comb begin
        logic w_found;
        int   w_idx;
        o_grant = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < N; k++) begin
            w_idx = (int'(i_base) + k) % N;
            if (!w_found && i_valid[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end else begin
                w_found = w_found;
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-back arbiter.
// Purpose : picks one of NREQ write-back requesters per cycle (grant is
//           combinational), registers the winning write one cycle later onto
//           the register-file write port, and drops writes aimed at register 0.
//           Default build: fixed priority (lowest index first) with per-requester
//           wait counters; a requester that has waited STARVE_MAX cycles is
//           promoted. Defining RF_WB_ARB_RR_EN replaces that with round-robin.
// Ports   : clk, rst (async, active-high)
//           req_valid/req_addr/req_data - packed requests, requester i at [i*W +: W]
//           req_ready                   - one-hot grant, handshake on valid&&ready
//           stall                       - blocks new grants
//           flush                       - blocks grants, kills next write, clears waits
//           rf_we/rf_waddr/rf_wdata     - register-file write port
//           grant_id                    - requester that produced the current write
//           zero_drop                   - pulse when an accepted write to r0 is dropped
module rf_wb_arbiter
    import rf_wb_pkg::*;
#(
    parameter int NREQ       = rf_wb_pkg::NREQ,
    parameter int AW         = rf_wb_pkg::AW,
    parameter int DW         = rf_wb_pkg::DW,
    parameter int STARVE_MAX = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    input  logic              stall,
    input  logic              flush,
    output logic              rf_we,
    output logic [AW-1:0]     rf_waddr,
    output logic [DW-1:0]     rf_wdata,
    output req_id_t           grant_id,
    output logic              zero_drop
);

    localparam int IW = $bits(req_id_t);

    logic [NREQ-1:0] w_pick_vec;
    logic [IW-1:0]   w_base;
    logic [NREQ-1:0] w_grant;
    logic            w_hs;
    req_id_t         w_win_id;
    logic [AW-1:0]   w_win_addr;
    logic [DW-1:0]   w_win_data;

`ifdef RF_WB_ARB_RR_EN
    logic [IW-1:0] r_ptr;

    // Round-robin: every valid requester competes, search starts at the pointer.
    always_comb begin
        w_pick_vec = req_valid;
        w_base     = r_ptr;
    end

    // Pointer moves just past the winner after each handshake; otherwise it holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_hs) begin
            if (w_win_id == req_id_t'(NREQ - 1)) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= w_win_id + 2'd1;
            end
        end else begin
            r_ptr <= r_ptr;
        end
    end
`else
    logic [2:0]      r_wait [NREQ];
    logic [NREQ-1:0] w_starved;

    // Starved requesters, if any, are the only candidates; otherwise all valid ones.
    always_comb begin
        w_starved = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_starved[i] = req_valid[i] && (r_wait[i] == 3'(STARVE_MAX));
        end
        if (|w_starved) begin
            w_pick_vec = w_starved;
        end else begin
            w_pick_vec = req_valid;
        end
        w_base = '0;
    end

    // Wait counters: count losing cycles, saturate, clear on win, idle or flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) begin
                r_wait[i] <= 3'd0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (flush || !req_valid[i] || req_ready[i]) begin
                    r_wait[i] <= 3'd0;
                end else begin
                    r_wait[i] <= sat_inc3(r_wait[i], 3'(STARVE_MAX));
                end
            end
        end
    end
`endif

    rf_wb_prio_pick #(
        .N  (NREQ),
        .IW (IW)
    ) u_pick (
        .i_valid (w_pick_vec),
        .i_base  (w_base),
        .o_grant (w_grant)
    );

    // Grants are withheld entirely while stalled or flushing.
    always_comb begin
        req_ready = w_grant & {NREQ{!stall && !flush}};
        w_hs      = |(req_ready & req_valid);
    end

    // Select id, address and data of the granted requester.
    always_comb begin
        w_win_id   = REQ_ALU;
        w_win_addr = '0;
        w_win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                w_win_id   = req_id_t'(i);
                w_win_addr = req_addr[i*AW +: AW];
                w_win_data = req_data[i*DW +: DW];
            end else begin
                w_win_id = w_win_id;
            end
        end
    end

    // Output stage: a handshake becomes a write next cycle; r0 writes become a drop pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            grant_id  <= REQ_ALU;
            zero_drop <= 1'b0;
        end else if (w_hs) begin
            rf_we     <= (w_win_addr != '0);
            zero_drop <= (w_win_addr == '0);
            rf_waddr  <= w_win_addr;
            rf_wdata  <= w_win_data;
            grant_id  <= w_win_id;
        end else begin
            rf_we     <= 1'b0;
            zero_drop <= 1'b0;
        end
    end

endmodule
